// File: rtl/count_mon_pkg.sv
// Shared types and constants for the down-counter monitor: FSM encoding and
// the active-high seven-segment glyph table.
package count_mon_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_ERR   = 2'd2
  } mon_state_t;

  // Segment order is {g,f,e,d,c,b,a}; a set bit means the segment is lit.
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F,  // 0
    7'h06,  // 1
    7'h5B,  // 2
    7'h4F,  // 3
    7'h66,  // 4
    7'h6D,  // 5
    7'h7D,  // 6
    7'h07,  // 7
    7'h7F,  // 8
    7'h6F,  // 9
    7'h77,  // A
    7'h7C,  // b
    7'h39,  // C
    7'h5E,  // d
    7'h79,  // E
    7'h71   // F
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to seven-segment decoder, active-high segments.
module hex_to_seg7
  import count_mon_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg_lookup(nibble);
  end

endmodule

// File: rtl/down_count_monitor.sv
// Checks that a sampled counter bus steps down by one each sample, counts
// wrap-arounds and sequence errors, and shows the last sample on a 7-seg digit.
//
// state   | meaning
// S_INIT  | no reference yet; next sample only loads prev
// S_TRACK | every sample so far stepped correctly
// S_ERR   | at least one bad step seen; checking continues
module down_count_monitor
  import count_mon_pkg::*;
#(
  parameter int CNT_W          = 4,
  parameter int WRAP_W         = 8,
  parameter int ERR_W          = 4,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  count_in,
  input  logic              sample_en,
  input  logic              clear,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              seq_err,
  output logic [ERR_W-1:0]  err_count,
  output logic [6:0]        hex_seg
);

  mon_state_t       state;
  mon_state_t       state_nxt;
  logic [CNT_W-1:0] prev;
  logic [CNT_W-1:0] exp_val;
  logic             step_ok;
  logic             checking;
  logic             wrap_hit;
  logic             err_hit;
  logic [3:0]       nibble;
  logic [6:0]       seg_raw;
  logic [6:0]       seg_drive;
  logic [6:0]       seg_off;

  // Only the low nibble is displayed on wider buses.
  assign nibble = 4'(count_in);

  hex_to_seg7 u_seg (
    .nibble (nibble),
    .seg    (seg_raw)
  );

  // Next state and expected successor.
  always_comb begin
    exp_val   = prev - CNT_W'(1);
    step_ok   = (count_in == exp_val);
    state_nxt = state;
    if (clear) begin
      state_nxt = S_INIT;
    end else if (sample_en) begin
      case (state)
        S_INIT:  state_nxt = S_TRACK;
        S_TRACK: state_nxt = step_ok ? S_TRACK : S_ERR;
        S_ERR:   state_nxt = S_ERR;
        default: state_nxt = S_INIT;
      endcase
    end
  end

  // Per-sample events and display polarity.
  always_comb begin
    checking  = sample_en && !clear && (state != S_INIT);
    wrap_hit  = checking && step_ok && (prev == '0);
    err_hit   = checking && !step_ok;
    seg_drive = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    seg_off   = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      prev       <= '0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      seq_err    <= 1'b0;
      err_count  <= '0;
      hex_seg    <= seg_off;
    end else begin
      state      <= state_nxt;
      wrap_pulse <= 1'b0;
      if (clear) begin
        // Soft clear leaves the display showing the last sample.
        prev       <= '0;
        wrap_count <= '0;
        seq_err    <= 1'b0;
        err_count  <= '0;
      end else if (sample_en) begin
        prev    <= count_in;
        hex_seg <= seg_drive;
        if (wrap_hit) begin
          wrap_pulse <= 1'b1;
          wrap_count <= wrap_count + WRAP_W'(1);
        end
        if (err_hit) begin
          seq_err <= 1'b1;
          if (err_count != '1) begin
            err_count <= err_count + ERR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_down_count_monitor.sv
// Randomized and directed checks of down_count_monitor against a behavioural model.
module tb_down_count_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_en = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic       seq_err;
  logic [3:0] err_count;
  logic [6:0] hex_seg;

  down_count_monitor #(
    .CNT_W(4), .WRAP_W(8), .ERR_W(4), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .count_in   (count_in),
    .sample_en  (sample_en),
    .clear      (clear),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .seq_err    (seq_err),
    .err_count  (err_count),
    .hex_seg    (hex_seg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit         m_init;
  int         m_prev;
  int         m_wrap;
  int         m_err;
  bit         m_seq;
  bit         m_pulse;
  logic [6:0] m_seg;

  // Board glyphs {g,f,e,d,c,b,a}, returned in active-low board form.
  function automatic logic [6:0] glyph(input int v);
    logic [6:0] s;
    case (v % 16)
      0: s = 7'b0111111;  1: s = 7'b0000110;  2: s = 7'b1011011;  3: s = 7'b1001111;
      4: s = 7'b1100110;  5: s = 7'b1101101;  6: s = 7'b1111101;  7: s = 7'b0000111;
      8: s = 7'b1111111;  9: s = 7'b1101111; 10: s = 7'b1110111; 11: s = 7'b1111100;
     12: s = 7'b0111001; 13: s = 7'b1011110; 14: s = 7'b1111001; default: s = 7'b1110001;
    endcase
    return ~s;
  endfunction

  function automatic logic [20:0] model_bundle();
    return {m_pulse, 8'(m_wrap), m_seq, 4'(m_err), m_seg};
  endfunction

  // Drive one clock of stimulus and advance the model; outputs settle by #1.
  task automatic cycle(input bit r, input bit se, input int v, input bit clr);
    rst = r; sample_en = se; count_in = 4'(v); clear = clr;
    @(posedge clk); #1;
    m_pulse = 0;
    if (r || clr) begin
      m_init = 0; m_prev = 0; m_wrap = 0; m_err = 0; m_seq = 0;
      if (r) m_seg = 7'h7F;
    end else if (se) begin
      if (m_init) begin
        if (v == (m_prev + 15) % 16) begin
          if (m_prev == 0) begin
            m_pulse = 1;
            m_wrap  = (m_wrap + 1) % 256;
          end
        end else begin
          m_seq = 1;
          if (m_err < 15) m_err++;
        end
      end
      m_init = 1;
      m_prev = v;
      m_seg  = glyph(v);
    end
    rst = 0; clear = 0;
  endtask

  task automatic test_reset();
    cycle(1, 1, 5, 0);
    cycle(1, 1, 7, 1);
    n_checks += 5;
    if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %0b exp 0", wrap_pulse); end
    if (wrap_count !== 8'd0) begin n_fail++; $display("FAIL reset_wrap got %0d exp 0", wrap_count); end
    if (seq_err !== 1'b0)    begin n_fail++; $display("FAIL reset_seq got %0b exp 0", seq_err); end
    if (err_count !== 4'd0)  begin n_fail++; $display("FAIL reset_err got %0d exp 0", err_count); end
    if (hex_seg !== 7'h7F)   begin n_fail++; $display("FAIL reset_blank got %h exp 7f", hex_seg); end
  endtask

  task automatic test_wrap();
    int seq_v [18];
    for (int i = 0; i < 16; i++) seq_v[i] = 15 - i;
    seq_v[16] = 15; seq_v[17] = 14;
    for (int i = 0; i < 18; i++) begin
      cycle(0, 1, seq_v[i], 0);
      n_checks++;
      if ({wrap_pulse, wrap_count, seq_err, err_count, hex_seg} !== model_bundle()) begin
        n_fail++;
        $display("FAIL wrap_step%0d got %h exp %h", i,
                 {wrap_pulse, wrap_count, seq_err, err_count, hex_seg}, model_bundle());
      end
      if (i == 16) begin
        n_checks++;
        if (wrap_pulse !== 1'b1) begin n_fail++; $display("FAIL wrap_pulse got %0b exp 1", wrap_pulse); end
      end
    end
    n_checks += 3;
    if (wrap_count !== 8'd1) begin n_fail++; $display("FAIL wrap_count got %0d exp 1", wrap_count); end
    if (seq_err !== 1'b0)    begin n_fail++; $display("FAIL wrap_seq got %0b exp 0", seq_err); end
    if (hex_seg !== 7'h06)   begin n_fail++; $display("FAIL wrap_hexE got %h exp 06", hex_seg); end
  endtask

  task automatic test_skip();
    int v [6] = '{9, 8, 7, 5, 4, 3};
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, v[i], 0);
      n_checks += 2;
      if (seq_err !== (i >= 3)) begin n_fail++; $display("FAIL skip_seq%0d got %0b exp %0b", i, seq_err, i >= 3); end
      if (err_count !== ((i >= 3) ? 4'd1 : 4'd0)) begin
        n_fail++; $display("FAIL skip_err%0d got %0d exp %0d", i, err_count, (i >= 3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_clear();
    int v [3] = '{1, 0, 15};
    cycle(0, 1, 2, 1);
    n_checks += 4;
    if (wrap_count !== 8'd0) begin n_fail++; $display("FAIL clr_wrap got %0d exp 0", wrap_count); end
    if (err_count !== 4'd0)  begin n_fail++; $display("FAIL clr_err got %0d exp 0", err_count); end
    if (seq_err !== 1'b0)    begin n_fail++; $display("FAIL clr_seq got %0b exp 0", seq_err); end
    if (hex_seg !== glyph(3)) begin n_fail++; $display("FAIL clr_hexhold got %h exp %h", hex_seg, glyph(3)); end
    for (int i = 0; i < 3; i++) cycle(0, 1, v[i], 0);
    n_checks += 3;
    if (wrap_count !== 8'd1) begin n_fail++; $display("FAIL clr_rewrap got %0d exp 1", wrap_count); end
    if (wrap_pulse !== 1'b1) begin n_fail++; $display("FAIL clr_repulse got %0b exp 1", wrap_pulse); end
    if (seq_err !== 1'b0)    begin n_fail++; $display("FAIL clr_reseq got %0b exp 0", seq_err); end
  endtask

  task automatic test_sample_gate();
    logic [6:0] held;
    held = hex_seg;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, $urandom_range(0, 15), 0);
      n_checks += 3;
      if (hex_seg !== held)    begin n_fail++; $display("FAIL gate_hex%0d got %h exp %h", i, hex_seg, held); end
      if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL gate_pulse%0d got %0b exp 0", i, wrap_pulse); end
      if (seq_err !== 1'b0)    begin n_fail++; $display("FAIL gate_seq%0d got %0b exp 0", i, seq_err); end
    end
    cycle(0, 1, 14, 0);
    n_checks += 2;
    if (seq_err !== 1'b0)  begin n_fail++; $display("FAIL gate_resume got %0b exp 0", seq_err); end
    if (hex_seg !== 7'h06) begin n_fail++; $display("FAIL gate_hex_resume got %h exp 06", hex_seg); end
  endtask

  task automatic test_saturate();
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 21; i++) cycle(0, 1, 3, 0);
    n_checks += 2;
    if (err_count !== 4'd15) begin n_fail++; $display("FAIL sat_err got %0d exp 15", err_count); end
    if (seq_err !== 1'b1)    begin n_fail++; $display("FAIL sat_seq got %0b exp 1", seq_err); end
  endtask

  task automatic test_mid_reset();
    cycle(0, 0, 0, 1);
    cycle(0, 1, 2, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 1, 15, 0);
    n_checks += 2;
    if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL mrst_pulse got %0b exp 0", wrap_pulse); end
    if (wrap_count !== 8'd0) begin n_fail++; $display("FAIL mrst_wrap got %0d exp 0", wrap_count); end
    cycle(0, 1, 14, 0);
    n_checks += 2;
    if (seq_err !== 1'b0)  begin n_fail++; $display("FAIL mrst_track got %0b exp 0", seq_err); end
    if (hex_seg !== 7'h06) begin n_fail++; $display("FAIL mrst_hex got %h exp 06", hex_seg); end
  endtask

  task automatic test_random();
    bit last_pulse = 0;
    for (int i = 0; i < 600; i++) begin
      int r, v;
      bit r_rst, r_clr, r_se;
      r     = $urandom_range(0, 199);
      r_rst = (r == 0);
      r_clr = (r >= 1 && r < 5);
      r_se  = (r >= 40);
      v     = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : (m_prev + 15) % 16;
      cycle(r_rst, r_se, v, r_clr);
      n_checks++;
      if ({wrap_pulse, wrap_count, seq_err, err_count, hex_seg} !== model_bundle()) begin
        n_fail++;
        $display("FAIL rand%0d got %h exp %h", i,
                 {wrap_pulse, wrap_count, seq_err, err_count, hex_seg}, model_bundle());
      end
      if (last_pulse && wrap_pulse) begin
        n_fail++; $display("FAIL rand_double_pulse%0d got 1 exp 0", i);
      end
      last_pulse = wrap_pulse;
    end
  endtask

  initial begin
    m_init = 0; m_prev = 0; m_wrap = 0; m_err = 0; m_seq = 0; m_pulse = 0; m_seg = 7'h7F;
    test_reset();
    test_wrap();
    test_skip();
    test_clear();
    test_sample_gate();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
